// File: rtl/irq_gen_pkg.sv
// ----------------------------------------------------------------------------
// irq_gen_pkg
//  Shared types and helpers for the IRQ stimulus/checker generator.
//  Contents:
//   state_e      per-channel FSM states
//   LFSR_POLY    32-bit Galois LFSR feedback mask
//   lfsr_next()  one Galois LFSR step (right shift, xor mask when lsb set)
//   chan_seed()  per-channel seed derivation, never returns 0
// ----------------------------------------------------------------------------
package irq_gen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      WAIT,
      GAP,
      DONE
   } state_e;

   // x^32 + x^22 + x^2 + x + 1, maximal length: a nonzero state never reaches 0
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

   // An all-zero seed would lock the LFSR at 0, so it is replaced by 1.
   function automatic logic [31:0] chan_seed(input logic [31:0] seed, input int unsigned idx);
      logic [31:0] s;
      s = seed ^ (32'(idx) << 8);
      if (s == 32'h0) begin
         s = 32'h1;
      end
      return s;
   endfunction

endpackage

// File: rtl/irq_gen_channel.sv
// ----------------------------------------------------------------------------
// irq_gen_channel
//  One CPU channel: drives LFSR vectors, waits for the echo, checks it,
//  inserts a gap, repeats TRANSACTION_NB times, then parks in DONE.
//  Ports:
//   clk       in   clock, posedge
//   rst_n     in   synchronous reset, active low
//   echo_i    in   32-bit echoed vector from the responder
//   irq_o     out  32-bit vector driven to the responder
//   done_o    out  channel finished (completed or aborted); sticky
//   error_o   out  timeout or bad echo seen; sticky
// ----------------------------------------------------------------------------
module irq_gen_channel
   import irq_gen_pkg::*;
#(
   parameter int unsigned TRANSACTION_NB = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter logic [31:0] CH_SEED        = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] echo_i,
   output logic [31:0] irq_o,
   output logic        done_o,
   output logic        error_o
);

   localparam int SENT_W = $clog2(TRANSACTION_NB + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   state_e              state_q, state_d;
   logic [31:0]         lfsr_q,  lfsr_d;
   logic [31:0]         irq_q,   irq_d;   // also serves as the expected echo
   logic [31:0]         prev_q,  prev_d;  // previous vector: a stale echo
   logic [SENT_W-1:0]   sent_q,  sent_d;
   logic [TMO_W-1:0]    tmo_q,   tmo_d;
   logic [GAP_W-1:0]    gap_q,   gap_d;
   logic                done_q,  done_d;
   logic                error_q, error_d;

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      irq_d   = irq_q;
      prev_d  = prev_q;
      sent_d  = sent_q;
      tmo_d   = tmo_q;
      gap_d   = gap_q;
      done_d  = done_q;
      error_d = error_q;
      case (state_q)
         IDLE: begin
            state_d = DRIVE;
         end
         DRIVE: begin
            lfsr_d  = lfsr_next(lfsr_q);
            irq_d   = lfsr_next(lfsr_q);
            prev_d  = irq_q;
            tmo_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A match is tested first so it wins over a same-cycle timeout.
            if (echo_i == irq_q) begin
               sent_d = sent_q + 1'b1;
               if (32'(sent_q) + 32'd1 == 32'(TRANSACTION_NB)) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (GAP_CYCLES == 0) begin
                  state_d = DRIVE;
               end else begin
                  gap_d   = '0;
                  state_d = GAP;
               end
            end else if ((echo_i != prev_q) ||
                         (32'(tmo_q) == 32'(TIMEOUT_CYCLES - 1))) begin
               error_d = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         GAP: begin
            if (32'(gap_q) + 32'd1 >= 32'(GAP_CYCLES)) begin
               state_d = DRIVE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lfsr_q  <= CH_SEED;
         irq_q   <= '0;
         prev_q  <= '0;
         sent_q  <= '0;
         tmo_q   <= '0;
         gap_q   <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         irq_q   <= irq_d;
         prev_q  <= prev_d;
         sent_q  <= sent_d;
         tmo_q   <= tmo_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign irq_o   = irq_q;
   assign done_o  = done_q;
   assign error_o = error_q;

endmodule

// File: rtl/irq_generator.sv
// ----------------------------------------------------------------------------
// irq_generator
//  IRQ stimulus/checker stage for the loopback responder: CPU_NB independent
//  channels, each sending TRANSACTION_NB LFSR vectors and checking the echo.
//  Ports:
//   clk          in   clock, posedge
//   rst_n        in   synchronous reset, active low
//   o_irq[n]     out  32-bit vector per channel
//   i_irq[n]     in   32-bit echo per channel
//   o_done_vec   out  per-channel finished flags (sticky)
//   o_error_vec  out  per-channel error flags (sticky)
//   o_all_done   out  all channels finished
//   o_any_error  out  any channel errored
// ----------------------------------------------------------------------------
module irq_generator
   import irq_gen_pkg::*;
#(
   parameter int unsigned CPU_NB         = 4,
   parameter int unsigned TRANSACTION_NB = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter logic [31:0] SEED           = 32'h0000_ACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [31:0]       o_irq [CPU_NB],
   input  logic [31:0]       i_irq [CPU_NB],
   output logic [CPU_NB-1:0] o_done_vec,
   output logic [CPU_NB-1:0] o_error_vec,
   output logic              o_all_done,
   output logic              o_any_error
);

   for (genvar gi = 0; gi < int'(CPU_NB); gi++) begin : g_chan
      irq_gen_channel #(
         .TRANSACTION_NB (TRANSACTION_NB),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .GAP_CYCLES     (GAP_CYCLES),
         .CH_SEED        (chan_seed(SEED, gi))
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .echo_i  (i_irq[gi]),
         .irq_o   (o_irq[gi]),
         .done_o  (o_done_vec[gi]),
         .error_o (o_error_vec[gi])
      );
   end

   assign o_all_done  = &o_done_vec;
   assign o_any_error = |o_error_vec;

endmodule

// File: tb/tb_irq_generator.sv
// ----------------------------------------------------------------------------
// tb_irq_generator
//  Drives irq_generator with a configurable echo responder (per-transaction
//  echo delay, corrupted echo, never-echo) and compares every emitted vector,
//  its cycle of appearance, and the done/error outcome against a
//  transaction-level timeline computed from the protocol rules.
// ----------------------------------------------------------------------------
module tb_irq_generator;

   localparam int CPU_NB = 2;
   localparam int TN     = 4;
   localparam int TMO    = 8;
   localparam int GAPC   = 2;
   localparam int BUDGET = 200;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       o_irq [CPU_NB];
   logic [31:0]       i_irq [CPU_NB];
   logic [CPU_NB-1:0] o_done_vec;
   logic [CPU_NB-1:0] o_error_vec;
   logic              o_all_done;
   logic              o_any_error;

   always #5 clk = ~clk;

   irq_generator #(
      .CPU_NB         (CPU_NB),
      .TRANSACTION_NB (TN),
      .TIMEOUT_CYCLES (TMO),
      .GAP_CYCLES     (GAPC),
      .SEED           (32'h0000_ACE1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .o_irq       (o_irq),
      .i_irq       (i_irq),
      .o_done_vec  (o_done_vec),
      .o_error_vec (o_error_vec),
      .o_all_done  (o_all_done),
      .o_any_error (o_any_error)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference LFSR step, written from the polynomial definition.
   function automatic logic [31:0] ref_step(input logic [31:0] x);
      if (x[0]) return (x >> 1) ^ 32'h8020_0003;
      return x >> 1;
   endfunction

   function automatic logic [31:0] seed_of(input int ch);
      logic [31:0] s;
      s = 32'h0000_ACE1 ^ (32'(ch) << 8);
      if (s == 32'h0) s = 32'h1;
      return s;
   endfunction

   // Scenario configuration: echo delay per transaction (>=8 means too late,
   // 99 means never) and the transaction index that gets a corrupted echo.
   int dly     [CPU_NB][TN];
   int bad_txn [CPU_NB];

   task automatic run_scn(input int scn, input int rst_len, input int abort_txn);
      logic [31:0]       exp_vec [CPU_NB][TN];
      int                exp_vis [CPU_NB][TN];
      int                exp_n   [CPU_NB];
      int                exp_end [CPU_NB];
      logic              exp_err [CPU_NB];
      logic [31:0]       seen    [CPU_NB];
      int                cnt     [CPU_NB];
      int                rtx     [CPU_NB];
      logic [31:0]       last_o  [CPU_NB];
      int                obs_n   [CPU_NB];
      logic [CPU_NB-1:0] last_done;
      logic [31:0]       v;
      int                t_vis, d, max_end, cyc;

      // Transaction timeline: vector visible at t_vis; an echo delayed d
      // cycles is accepted at t_vis+d+1; the next vector appears GAP+1 later.
      max_end = 0;
      for (int ch = 0; ch < CPU_NB; ch++) begin
         v = seed_of(ch);
         t_vis = 2;
         exp_n[ch] = 0;
         exp_err[ch] = 1'b0;
         exp_end[ch] = 0;
         for (int k = 0; k < TN; k++) begin
            v = ref_step(v);
            exp_vec[ch][k] = v;
            exp_vis[ch][k] = t_vis;
            exp_n[ch] = k + 1;
            d = dly[ch][k];
            if (d >= TMO) begin
               exp_err[ch] = 1'b1;
               exp_end[ch] = t_vis + TMO;
               break;
            end
            if (bad_txn[ch] == k) begin
               exp_err[ch] = 1'b1;
               exp_end[ch] = t_vis + d + 1;
               break;
            end
            if (k == TN - 1) begin
               exp_end[ch] = t_vis + d + 1;
            end
            t_vis = t_vis + d + 1 + GAPC + 1;
         end
         if (exp_end[ch] > max_end) max_end = exp_end[ch];
      end

      rst_n = 1'b0;
      for (int ch = 0; ch < CPU_NB; ch++) i_irq[ch] = 32'h0;
      repeat (rst_len) @(negedge clk);
      for (int ch = 0; ch < CPU_NB; ch++) check_eq("rst_irq", o_irq[ch], 32'h0);
      check_eq("rst_done", 32'(o_done_vec), 32'h0);
      check_eq("rst_error", 32'(o_error_vec), 32'h0);

      for (int ch = 0; ch < CPU_NB; ch++) begin
         seen[ch] = 32'h0; cnt[ch] = 0; rtx[ch] = 0;
         last_o[ch] = 32'h0; obs_n[ch] = 0;
      end
      last_done = '0;
      cyc = 0;
      rst_n = 1'b1;

      while (cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         for (int ch = 0; ch < CPU_NB; ch++) begin
            if (o_irq[ch] !== last_o[ch]) begin
               $display("scn=%0d cpu=%0d txn=%0d vec=%h cyc=%0d", scn, ch, obs_n[ch], o_irq[ch], cyc);
               if (obs_n[ch] < exp_n[ch]) begin
                  check_eq("vec_value", o_irq[ch], exp_vec[ch][obs_n[ch]]);
                  check_eq("vec_cycle", 32'(cyc), 32'(exp_vis[ch][obs_n[ch]]));
               end else begin
                  check_eq("extra_vec", 32'(obs_n[ch] + 1), 32'(exp_n[ch]));
               end
               obs_n[ch]++;
               last_o[ch] = o_irq[ch];
            end
            if (o_done_vec[ch] && !last_done[ch]) begin
               check_eq("done_cycle", 32'(cyc), 32'(exp_end[ch]));
               check_eq("err_at_done", 32'(o_error_vec[ch]), 32'(exp_err[ch]));
            end
         end
         last_done = o_done_vec;

         if (abort_txn >= 0 && obs_n[0] == abort_txn + 1) begin
            rst_n = 1'b0;
            @(negedge clk);
            for (int ch = 0; ch < CPU_NB; ch++) check_eq("abort_irq", o_irq[ch], 32'h0);
            check_eq("abort_done", 32'(o_done_vec), 32'h0);
            check_eq("abort_error", 32'(o_error_vec), 32'h0);
            return;
         end

         // Responder: echo the new vector d cycles after it shows up.
         for (int ch = 0; ch < CPU_NB; ch++) begin
            if (cnt[ch] > 0) begin
               cnt[ch]--;
               if (cnt[ch] == 0) begin
                  i_irq[ch] = (bad_txn[ch] == rtx[ch] - 1) ? (seen[ch] ^ 32'h1) : seen[ch];
               end
            end
            if (o_irq[ch] !== seen[ch]) begin
               seen[ch] = o_irq[ch];
               rtx[ch]++;
               cnt[ch] = (rtx[ch] <= TN) ? dly[ch][rtx[ch] - 1] : 1;
            end
         end

         if (o_all_done && cyc >= max_end + 3) break;
      end

      for (int ch = 0; ch < CPU_NB; ch++) begin
         check_eq("end_done", 32'(o_done_vec[ch]), 32'h1);
         check_eq("end_error", 32'(o_error_vec[ch]), 32'(exp_err[ch]));
         check_eq("vec_count", 32'(obs_n[ch]), 32'(exp_n[ch]));
      end
      check_eq("all_done", 32'(o_all_done), 32'h1);
      check_eq("any_error", 32'(o_any_error), 32'(exp_err[0] | exp_err[1]));
   endtask

   task automatic cfg_all(input int lo, input int hi);
      for (int ch = 0; ch < CPU_NB; ch++) begin
         bad_txn[ch] = -1;
         for (int k = 0; k < TN; k++) dly[ch][k] = int'($urandom_range(hi, lo));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int ch = 0; ch < CPU_NB; ch++) i_irq[ch] = 32'h0;

      // Ideal registered responder on both channels
      cfg_all(1, 1);
      run_scn(1, 3, -1);

      // cpu0 never echoes: timeout on the first transaction
      cfg_all(1, 1);
      dly[0][0] = 99;
      run_scn(2, 3, -1);

      // cpu1 corrupts the echo of transaction 2
      cfg_all(1, 7);
      bad_txn[1] = 1;
      run_scn(3, 3, -1);

      // Reset pulse while cpu0 waits on transaction 3, then a clean rerun
      cfg_all(1, 7);
      run_scn(4, 3, 2);
      cfg_all(1, 7);
      run_scn(5, 0, -1);

      // Echo on the last allowed cycle, then one cycle too late
      cfg_all(1, 3);
      dly[1][1] = TMO - 1;
      run_scn(6, 3, -1);
      cfg_all(1, 3);
      dly[1][2] = TMO;
      run_scn(7, 3, -1);

      // Random mixes
      for (int s = 8; s < 16; s++) begin
         cfg_all(1, 7);
         for (int ch = 0; ch < CPU_NB; ch++) begin
            for (int k = 0; k < TN; k++) begin
               if ($urandom_range(7, 0) == 0) dly[ch][k] = int'($urandom_range(10, TMO));
            end
            if ($urandom_range(3, 0) == 0) bad_txn[ch] = int'($urandom_range(TN - 1, 0));
         end
         run_scn(s, 2, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
